// File: rtl/ecc_point_sequencer.sv
// Affine EC point addition/doubling sequencer driving a GFAU through a fixed micro-op ROM.
// Latency: add/sub op 2 cycles, mult/div op GFAU latency + 1; inf/err shortcut done 3 cycles after start.
// Backpressure: start is ignored while busy; each GFAU op waits for its matching completion pulse.
//
// Ports:
//   i_clk, i_rst (async active-low)          clock and reset
//   start, x1, y1, x2, y2, curve_a           request and operands, sampled on accepted start
//   busy, done, x3, y3, inf, err             status and result (result holds until next done)
//   gfau_in_0, gfau_in_1, gfau_op, gfau_req  GFAU operand/operation drive
//   gfau_result, gfau_done_mult/div          GFAU result and per-operation completion
//
// Build option: define ECC_DOUBLE_EN to include the point-doubling program. Without it,
// doubling requests (P == Q, y != 0) finish immediately with err set.

module ecc_point_sequencer #(
    parameter int SIZE = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            start,
    input  logic [SIZE-1:0] x1,
    input  logic [SIZE-1:0] y1,
    input  logic [SIZE-1:0] x2,
    input  logic [SIZE-1:0] y2,
    input  logic [SIZE-1:0] curve_a,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] x3,
    output logic [SIZE-1:0] y3,
    output logic            inf,
    output logic            err,
    output logic [SIZE-1:0] gfau_in_0,
    output logic [SIZE-1:0] gfau_in_1,
    output logic [1:0]      gfau_op,
    output logic            gfau_req,
    input  logic [SIZE-1:0] gfau_result,
    input  logic            gfau_done_mult,
    input  logic            gfau_done_div
);

    // FSM states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CLASSIFY = 3'd1;
    localparam logic [2:0] ST_EXEC     = 3'd2;
    localparam logic [2:0] ST_NEXT     = 3'd3;
    localparam logic [2:0] ST_FINISH   = 3'd4;

    // GFAU operation codes
    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MULT = 2'd2;
    localparam logic [1:0] OP_DIV  = 2'd3;

    // Register file indices
    localparam logic [2:0] RF_X1  = 3'd0;
    localparam logic [2:0] RF_Y1  = 3'd1;
    localparam logic [2:0] RF_X2  = 3'd2;
    localparam logic [2:0] RF_Y2  = 3'd3;
    localparam logic [2:0] RF_A   = 3'd4;
    localparam logic [2:0] RF_LAM = 3'd5;
    localparam logic [2:0] RF_T0  = 3'd6;
    localparam logic [2:0] RF_T1  = 3'd7;

    // Program boundaries in the ROM
    localparam logic [4:0] ADD_FIRST = 5'd0;
    localparam logic [4:0] ADD_LAST  = 5'd8;
`ifdef ECC_DOUBLE_EN
    localparam logic [4:0] DBL_FIRST = 5'd9;
    localparam logic [4:0] DBL_LAST  = 5'd20;
`endif

    // ROM entry layout: {op[10:9], srcA[8:6], srcB[5:3], dst[2:0]}
    function automatic logic [10:0] f_rom(input logic [4:0] pc);
        logic [10:0] e;
        e = '0;
        case (pc)
            // ADD: lam = (y2-y1)/(x2-x1); x3 = lam^2-x1-x2; y3 = lam*(x1-x3)-y1
            5'd0:  e = {OP_SUB,  RF_Y2,  RF_Y1,  RF_T0};
            5'd1:  e = {OP_SUB,  RF_X2,  RF_X1,  RF_T1};
            5'd2:  e = {OP_DIV,  RF_T0,  RF_T1,  RF_LAM};
            5'd3:  e = {OP_MULT, RF_LAM, RF_LAM, RF_T0};
            5'd4:  e = {OP_SUB,  RF_T0,  RF_X1,  RF_T0};
            5'd5:  e = {OP_SUB,  RF_T0,  RF_X2,  RF_T0};
            5'd6:  e = {OP_SUB,  RF_X1,  RF_T0,  RF_T1};
            5'd7:  e = {OP_MULT, RF_LAM, RF_T1,  RF_T1};
            5'd8:  e = {OP_SUB,  RF_T1,  RF_Y1,  RF_T1};
`ifdef ECC_DOUBLE_EN
            // DOUBLE: lam = (3*x1^2 + a)/(2*y1); tail reuses the ADD tail with X1 for X2
            5'd9:  e = {OP_MULT, RF_X1,  RF_X1,  RF_T0};
            5'd10: e = {OP_ADD,  RF_T0,  RF_T0,  RF_T1};
            5'd11: e = {OP_ADD,  RF_T1,  RF_T0,  RF_T1};
            5'd12: e = {OP_ADD,  RF_T1,  RF_A,   RF_T1};
            5'd13: e = {OP_ADD,  RF_Y1,  RF_Y1,  RF_T0};
            5'd14: e = {OP_DIV,  RF_T1,  RF_T0,  RF_LAM};
            5'd15: e = {OP_MULT, RF_LAM, RF_LAM, RF_T0};
            5'd16: e = {OP_SUB,  RF_T0,  RF_X1,  RF_T0};
            5'd17: e = {OP_SUB,  RF_T0,  RF_X1,  RF_T0};
            5'd18: e = {OP_SUB,  RF_X1,  RF_T0,  RF_T1};
            5'd19: e = {OP_MULT, RF_LAM, RF_T1,  RF_T1};
            5'd20: e = {OP_SUB,  RF_T1,  RF_Y1,  RF_T1};
`endif
            default: e = '0;
        endcase
        return e;
    endfunction

    logic [2:0]      r_state;
    logic [4:0]      r_pc;
    logic [4:0]      r_pc_last;
    logic [2:0]      r_dst;
    logic [SIZE-1:0] r_rf [0:7];
    logic            r_busy;
    logic            r_done;
    logic            r_inf;
    logic            r_err;
    logic [SIZE-1:0] r_x3;
    logic [SIZE-1:0] r_y3;
    logic [SIZE-1:0] r_in0;
    logic [SIZE-1:0] r_in1;
    logic [1:0]      r_op;

    logic            w_x_eq;
    logic            w_y_eq;
    logic            w_y_zero;
    logic [4:0]      w_pc_first;
    logic [4:0]      w_pc_last_sel;
    logic [4:0]      w_pc_load;
    logic [10:0]     w_rom;
    logic            w_cap;

    assign w_x_eq   = (r_rf[RF_X1] == r_rf[RF_X2]);
    assign w_y_eq   = (r_rf[RF_Y1] == r_rf[RF_Y2]);
    assign w_y_zero = (r_rf[RF_Y1] == '0);

`ifdef ECC_DOUBLE_EN
    logic w_dbl;
    assign w_dbl         = w_x_eq && w_y_eq && !w_y_zero;
    assign w_pc_first    = w_dbl ? DBL_FIRST : ADD_FIRST;
    assign w_pc_last_sel = w_dbl ? DBL_LAST  : ADD_LAST;
`else
    assign w_pc_first    = ADD_FIRST;
    assign w_pc_last_sel = ADD_LAST;
`endif

    // Operands for the next EXEC are fetched one cycle early (in CLASSIFY or NEXT) so
    // the GFAU inputs are registered and stable for the whole EXEC state.
    assign w_pc_load = (r_state == ST_CLASSIFY) ? w_pc_first : (r_pc + 5'd1);
    assign w_rom     = f_rom(w_pc_load);

    // Add/sub results are combinational in the GFAU; mult/div wait for their own pulse,
    // so a completion pulse of the wrong kind is simply ignored.
    assign w_cap = (r_state == ST_EXEC) &&
                   ((r_op == OP_ADD) || (r_op == OP_SUB) ||
                    ((r_op == OP_MULT) && gfau_done_mult) ||
                    ((r_op == OP_DIV)  && gfau_done_div));

    // Dropping req in the divider's completion cycle keeps it from re-arming.
    assign gfau_req = (r_state == ST_EXEC) && !gfau_done_div;

    assign busy      = r_busy;
    assign done      = r_done;
    assign inf       = r_inf;
    assign err       = r_err;
    assign x3        = r_x3;
    assign y3        = r_y3;
    assign gfau_in_0 = r_in0;
    assign gfau_in_1 = r_in1;
    assign gfau_op   = r_op;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_pc_last <= '0;
            r_dst     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_inf     <= 1'b0;
            r_err     <= 1'b0;
            r_x3      <= '0;
            r_y3      <= '0;
            r_in0     <= '0;
            r_in1     <= '0;
            r_op      <= '0;
            for (int i = 0; i < 8; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rf[RF_X1] <= x1;
                        r_rf[RF_Y1] <= y1;
                        r_rf[RF_X2] <= x2;
                        r_rf[RF_Y2] <= y2;
                        r_rf[RF_A]  <= curve_a;
                        r_inf       <= 1'b0;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_CLASSIFY;
                    end
                end

                ST_CLASSIFY: begin
                    if (!w_x_eq) begin
                        r_pc      <= w_pc_load;
                        r_pc_last <= w_pc_last_sel;
                        r_op      <= w_rom[10:9];
                        r_in0     <= r_rf[w_rom[8:6]];
                        r_in1     <= r_rf[w_rom[5:3]];
                        r_dst     <= w_rom[2:0];
                        r_state   <= ST_EXEC;
                    end else if (!w_y_eq || w_y_zero) begin
                        // P == -Q, or tangent is vertical: result is the point at infinity
                        r_inf   <= 1'b1;
                        r_state <= ST_FINISH;
                    end else begin
`ifdef ECC_DOUBLE_EN
                        r_pc      <= w_pc_load;
                        r_pc_last <= w_pc_last_sel;
                        r_op      <= w_rom[10:9];
                        r_in0     <= r_rf[w_rom[8:6]];
                        r_in1     <= r_rf[w_rom[5:3]];
                        r_dst     <= w_rom[2:0];
                        r_state   <= ST_EXEC;
`else
                        r_err   <= 1'b1;
                        r_state <= ST_FINISH;
`endif
                    end
                end

                ST_EXEC: begin
                    if (w_cap) begin
                        r_rf[r_dst] <= gfau_result;
                        r_state     <= ST_NEXT;
                    end
                end

                ST_NEXT: begin
                    if (r_pc == r_pc_last) begin
                        r_state <= ST_FINISH;
                    end else begin
                        r_pc    <= w_pc_load;
                        r_op    <= w_rom[10:9];
                        r_in0   <= r_rf[w_rom[8:6]];
                        r_in1   <= r_rf[w_rom[5:3]];
                        r_dst   <= w_rom[2:0];
                        r_state <= ST_EXEC;
                    end
                end

                ST_FINISH: begin
                    r_x3    <= (r_inf || r_err) ? '0 : r_rf[RF_T0];
                    r_y3    <= (r_inf || r_err) ? '0 : r_rf[RF_T1];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
